// File: rtl/fixed_rice_param_estimator.sv
// Per-partition |residual| accumulator and Rice parameter estimator (k = floor(log2(mean))).
// Define RICE_PARAM_FAST_EN to resolve k in a single cycle instead of one step per cycle.
module fixed_rice_param_estimator #(
  parameter int BLOCK_SIZE = 4096,
  parameter int WARMUP     = 3,
  parameter int MAX_K      = 14
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic               iValid,
  input  logic signed [15:0] iResidual,
  output logic               oBusy,
  output logic               oDone,
  output logic [3:0]         oK,
  output logic [31:0]        oSum
);

  localparam int          NEFF    = BLOCK_SIZE - WARMUP;
  localparam int          CNT_W   = $clog2(BLOCK_SIZE + 1);
  localparam logic [31:0] NEFF_W  = 32'(NEFF);
  localparam logic [3:0]  MAX_K_W = 4'(MAX_K);

  typedef enum logic [1:0] {ACCUM, SEARCH, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      sum_q;
  logic [3:0]       k_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       k_out_q;
  logic [31:0]      sum_out_q;

  logic             accept;
  logic [31:0]      abs_ext;

  // Magnitude as 17-bit unsigned so that -32768 maps to 32768.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic signed [16:0] ext;
    ext = {v[15], v};
    return ext[16] ? 17'(-ext) : 17'(ext);
  endfunction

  assign accept  = iEnable && iValid && (state_q == ACCUM) && !busy_q;
  assign abs_ext = {15'd0, abs17(iResidual)};

`ifdef RICE_PARAM_FAST_EN
  logic [3:0] k_fast;

  always_comb begin
    k_fast = '0;
    for (int i = 0; i <= MAX_K; i++) begin
      if ((NEFF_W << i) <= sum_q) k_fast = 4'(i);
    end
  end
`else
  logic [4:0] k_next;
  logic       k_step;

  // Advance k while the mean still reaches the next power of two.
  assign k_next = {1'b0, k_q} + 5'd1;
  assign k_step = (k_q < MAX_K_W) && ((NEFF_W << k_next) <= sum_q);
`endif

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q   <= ACCUM;
      cnt_q     <= '0;
      sum_q     <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      k_out_q   <= '0;
      sum_out_q <= '0;
    end else if (iEnable) begin
      // Busy lags the state by one cycle so it also covers the oDone cycle.
      busy_q <= (state_q != ACCUM);
      done_q <= (state_q == DONE);
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (cnt_q >= CNT_W'(WARMUP)) sum_q <= sum_q + abs_ext;
            if (cnt_q == CNT_W'(BLOCK_SIZE - 1)) begin
              state_q <= SEARCH;
              k_q     <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        SEARCH: begin
`ifdef RICE_PARAM_FAST_EN
          k_q     <= k_fast;
          state_q <= DONE;
`else
          if (k_step) k_q <= k_next[3:0];
          else        state_q <= DONE;
`endif
        end
        DONE: begin
          k_out_q   <= k_q;
          sum_out_q <= sum_q;
          sum_q     <= '0;
          state_q   <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign oBusy = busy_q;
  assign oDone = done_q;
  assign oK    = k_out_q;
  assign oSum  = sum_out_q;

endmodule

// File: tb/tb_fixed_rice_param_estimator.sv
// Bench for fixed_rice_param_estimator: table of partitions plus hand-written corner sequences,
// results checked through an expected-result queue popped on each oDone pulse.
module tb_fixed_rice_param_estimator;

  localparam int BS = 8;
  localparam int WU = 3;
  localparam int MK = 14;

  logic               iClock;
  logic               iReset;
  logic               iEnable;
  logic               iValid;
  logic signed [15:0] iResidual;
  logic               oBusy;
  logic               oDone;
  logic [3:0]         oK;
  logic [31:0]        oSum;

  fixed_rice_param_estimator #(.BLOCK_SIZE(BS), .WARMUP(WU), .MAX_K(MK)) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iValid(iValid),
    .iResidual(iResidual), .oBusy(oBusy), .oDone(oDone), .oK(oK), .oSum(oSum)
  );

  typedef struct packed {
    logic [7:0][15:0] s;
    logic [31:0]      sum;
    logic [3:0]       k;
  } vec_t;

  typedef struct {
    int sum;
    int k;
    int at_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;
  always @(posedge iClock) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int lat(input int k);
`ifdef RICE_PARAM_FAST_EN
    return 2;
`else
    return k + 2;
`endif
  endfunction

  function automatic vec_t mkv(input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7,
                               input int sm, input int kk);
    vec_t v;
    v.s[0] = 16'(a0); v.s[1] = 16'(a1); v.s[2] = 16'(a2); v.s[3] = 16'(a3);
    v.s[4] = 16'(a4); v.s[5] = 16'(a5); v.s[6] = 16'(a6); v.s[7] = 16'(a7);
    v.sum = 32'(sm);
    v.k   = 4'(kk);
    return v;
  endfunction

  // Scoreboard: every rising oDone must match the oldest expected result.
  always @(negedge iClock) begin
    if (oDone && !done_prev) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: oK=%0d oSum=%0d at cycle %0d", oK, oSum, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("oSum", oSum, e.sum);
        check("oK", oK, e.k);
        check("done_cycle", cyc, e.at_cyc);
      end
    end
    done_prev = oDone;
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic send(input int v);
    iValid    = 1'b1;
    iResidual = 16'(v);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || oBusy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: queue=%0d busy=%0d after %0d cycles", q.size(), oBusy, n);
    end
  endtask

  vec_t vecs[8];
  int   e0;
  int   d1;

  initial begin
    vecs[0] = mkv(1000, 1000, 1000, 0, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkv(0, 0, 0, 10, -10, 10, -10, 10, 50, 3);
    vecs[2] = mkv(0, 0, 0, -32768, -32768, -32768, -32768, -32768, 163840, 14);
    vecs[3] = mkv(5, 5, 5, 1, 1, 1, 1, 1, 5, 0);
    vecs[4] = mkv(0, 0, 0, 2, 2, 2, 2, 2, 10, 1);
    vecs[5] = mkv(0, 0, 0, 32767, 32767, 32767, 32767, 32767, 163835, 14);
    vecs[6] = mkv(-32768, -32768, -32768, 1, 2, 3, 4, 5, 15, 1);
    vecs[7] = mkv(0, 0, 0, 100, -200, 300, -400, 500, 1500, 8);

    iReset = 1'b1; iEnable = 1'b1; iValid = 1'b0; iResidual = '0;
    repeat (3) tick();
    check("rst_busy", oBusy, 0);
    check("rst_done", oDone, 0);
    check("rst_k", oK, 0);
    check("rst_sum", oSum, 0);
    iReset = 1'b0;
    tick();

    // Table of partitions, odd entries with idle gaps between samples.
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < BS; i++) begin
        send(int'($signed(vecs[v].s[i])));
        if ((v % 2) == 1 && i != BS - 1) begin
          iValid = 1'b0;
          tick();
        end
      end
      iValid = 1'b0;
      e0 = cyc;
      q.push_back('{sum: int'(vecs[v].sum), k: int'(vecs[v].k), at_cyc: e0 + lat(int'(vecs[v].k))});
      check("busy_after_e0", oBusy, 0);
      tick();
      check("busy_e0_plus1", oBusy, 1);
      wait_idle();
    end

    // iValid held high through the busy window: dropped samples must not be counted.
    for (int i = 0; i < BS; i++) send(7);
    e0 = cyc;
    d1 = e0 + lat(2);
    q.push_back('{sum: 35, k: 2, at_cyc: d1});
    q.push_back('{sum: 35, k: 2, at_cyc: d1 + 1 + BS + lat(2)});
    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
        tick();
        n++;
      end
      if (n >= 300) begin
        tests++;
        fails++;
        $display("FAIL held_valid_timeout: queue=%0d", q.size());
      end
    end
    iValid = 1'b0;
    wait_idle();

    // iEnable low for 3 cycles while searching delays oDone by exactly 3.
    for (int i = 0; i < BS; i++) send((i < WU) ? 0 : ((i % 2) ? 10 : -10));
    iValid = 1'b0;
    e0 = cyc;
    q.push_back('{sum: 50, k: 3, at_cyc: e0 + lat(3) + 3});
    iEnable = 1'b0;
    repeat (3) tick();
    iEnable = 1'b1;
    wait_idle();

    // Mid-partition reset discards the partial sum and count.
    for (int i = 0; i < 4; i++) send(1000);
    iValid = 1'b0;
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    check("midrst_k", oK, 0);
    check("midrst_sum", oSum, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_done", oDone, 0);
    for (int i = 0; i < BS; i++) send(10);
    iValid = 1'b0;
    e0 = cyc;
    q.push_back('{sum: 50, k: 3, at_cyc: e0 + lat(3)});
    wait_idle();

    repeat (5) tick();
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
